// File: rtl/mod_alu_seq.sv
// Sequential modular ADD/SUB/MUL/NEG unit, results in [0, M-1].
// Latency: accept+2 for ADD/SUB/NEG, accept+1+W for MUL; the result is held until out_ready and in_ready is low while busy.
module mod_alu_seq #(
  parameter int W = 4,
  parameter int M = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NEG = 2'b11;

  // W+1 bits so that M = 2^W is representable and sums never overflow
  localparam logic [W:0] MOD = (W+1)'(M);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W-1);

  logic [1:0]    state;
  logic [1:0]    opr;
  logic [W-1:0]  xr, yr;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;

  logic          bad_in;
  logic [W:0]    xe, ye, s_add, s_sub, dbl, dbl_r, mac;
  logic [W-1:0]  mul_next, calc_z;

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  assign bad_in = ({1'b0, x} >= MOD) || ((op != OP_NEG) && ({1'b0, y} >= MOD));

  always_comb begin
    xe    = {1'b0, xr};
    ye    = {1'b0, yr};
    s_add = xe + ye;
    s_sub = xe + MOD - ye;
    // one MSB-first shift-add step: acc*2 + (bit ? x : 0), reduced after each add
    dbl   = {acc, 1'b0};
    dbl_r = (dbl >= MOD) ? dbl - MOD : dbl;
    mac   = yr[cnt] ? dbl_r + xe : dbl_r;
    mul_next = (mac >= MOD) ? W'(mac - MOD) : W'(mac);
    calc_z = mul_next;
    case (opr)
      OP_ADD:  calc_z = (s_add >= MOD) ? W'(s_add - MOD) : W'(s_add);
      OP_SUB:  calc_z = (xe >= ye) ? W'(xe - ye) : W'(s_sub);
      OP_NEG:  calc_z = (xr == '0) ? '0 : W'(MOD - xe);
      default: calc_z = mul_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      opr   <= OP_ADD;
      xr    <= '0;
      yr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      z     <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            xr  <= x;
            yr  <= y;
            opr <= op;
            acc <= '0;
            cnt <= CNT_TOP;
            if (bad_in) begin
              z     <= '0;
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if ((opr == OP_MUL) && (cnt != '0)) begin
            acc <= mul_next;
            cnt <= cnt - CW'(1);
          end else begin
            z     <= calc_z;
            err   <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_alu_seq.sv
// Bench for mod_alu_seq: directed vectors plus an integer-arithmetic model checked every cycle on three parameter sets.
module tb_mod_alu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv[3];
  logic [1:0] opv[3];
  int         xv[3], yv[3];
  logic       ordy[3];

  logic       ov0, ov1, ov2, rd0, rd1, rd2, e0, e1, e2;
  logic [3:0] z0, z1;
  logic [4:0] z2;

  logic ov[3], rdy[3], ev[3];
  int   zv[3];

  assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
  assign rdy[0] = rd0; assign rdy[1] = rd1; assign rdy[2] = rd2;
  assign ev[0] = e0;   assign ev[1] = e1;   assign ev[2] = e2;
  assign zv[0] = 32'(z0); assign zv[1] = 32'(z1); assign zv[2] = 32'(z2);

  mod_alu_seq #(.W(4), .M(10)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rd0), .op(opv[0]),
    .x(xv[0][3:0]), .y(yv[0][3:0]), .out_valid(ov0), .out_ready(ordy[0]), .z(z0), .err(e0));

  mod_alu_seq #(.W(4), .M(16)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rd1), .op(opv[1]),
    .x(xv[1][3:0]), .y(yv[1][3:0]), .out_valid(ov1), .out_ready(ordy[1]), .z(z1), .err(e1));

  mod_alu_seq #(.W(5), .M(17)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rd2), .op(opv[2]),
    .x(xv[2][4:0]), .y(yv[2][4:0]), .out_valid(ov2), .out_ready(ordy[2]), .z(z2), .err(e2));

  int n_tests = 0;
  int n_fail  = 0;

  function automatic int m_of(int k);
    case (k)
      0: return 10;
      1: return 16;
      default: return 17;
    endcase
  endfunction

  function automatic int w_of(int k);
    return (k == 2) ? 5 : 4;
  endfunction

  function automatic int ref_z(int k, int op, int a, int b);
    int m;
    m = m_of(k);
    case (op)
      0: return (a + b) % m;
      1: return (a - b + m) % m;
      2: return (a * b) % m;
      default: return (m - a) % m;
    endcase
  endfunction

  function automatic bit ref_bad(int k, int op, int a, int b);
    return (a >= m_of(k)) || ((op != 3) && (b >= m_of(k)));
  endfunction

  task automatic check(string name, int k, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, k, act, exp, $time);
    end
  endtask

  // Transaction-level model: an accepted op yields its integer result after a fixed latency
  bit m_busy[3], m_vld[3], m_err[3];
  int m_left[3], m_z[3], m_res[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_busy[k] <= 1'b0;
        m_vld[k]  <= 1'b0;
        m_z[k]    <= 0;
        m_err[k]  <= 1'b0;
      end else if (m_vld[k]) begin
        if (ordy[k]) m_vld[k] <= 1'b0;
      end else if (m_busy[k]) begin
        if (m_left[k] == 1) begin
          m_busy[k] <= 1'b0;
          m_vld[k]  <= 1'b1;
          m_z[k]    <= m_res[k];
          m_err[k]  <= 1'b0;
        end else begin
          m_left[k] <= m_left[k] - 1;
        end
      end else if (iv[k]) begin
        if (ref_bad(k, int'(opv[k]), xv[k], yv[k])) begin
          m_vld[k] <= 1'b1;
          m_z[k]   <= 0;
          m_err[k] <= 1'b1;
        end else begin
          m_busy[k] <= 1'b1;
          m_res[k]  <= ref_z(k, int'(opv[k]), xv[k], yv[k]);
          m_left[k] <= (opv[k] == 2'b10) ? w_of(k) : 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check("out_valid", k, int'(ov[k]), int'(m_vld[k]));
      check("in_ready", k, int'(rdy[k]), int'(!(m_busy[k] || m_vld[k])));
      if (m_vld[k]) begin
        check("z", k, zv[k], m_z[k]);
        check("err", k, int'(ev[k]), int'(m_err[k]));
      end
    end
  end

  // Issue one op on instance k and wait for its result; lat counts cycles from accept edge
  task automatic do_op(int k, logic [1:0] op, int a, int b, bit lit, int ez, int ee, int elat);
    int waitc = 0;
    int lat;
    while (!rdy[k] && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("rdy_wait", k, int'(rdy[k]), 1);
    iv[k] = 1'b1; opv[k] = op; xv[k] = a; yv[k] = b;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = 1;
    while (!ov[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lit) begin
      check("latency", k, lat, elat);
      check("z_lit", k, zv[k], ez);
      check("err_lit", k, int'(ev[k]), ee);
    end else begin
      check("done_wait", k, int'(ov[k]), 1);
    end
  endtask

  task automatic sweep(int k);
    int m;
    m = m_of(k);
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < m; a++)
        for (int b = 0; b < ((op == 3) ? 1 : m); b++)
          do_op(k, 2'(op), a, b, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; opv[k] = 2'b00; xv[k] = 0; yv[k] = 0; ordy[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("rst_out_valid", k, int'(ov[k]), 0);
      check("rst_in_ready", k, int'(rdy[k]), 1);
      check("rst_z", k, zv[k], 0);
      check("rst_err", k, int'(ev[k]), 0);
    end

    do_op(0, 2'b00, 7, 5, 1'b1, 2, 0, 2);
    @(posedge clk); #1;
    check("rdy_back", 0, int'(rdy[0]), 1);
    do_op(0, 2'b01, 3, 8, 1'b1, 5, 0, 2);
    do_op(0, 2'b11, 0, 0, 1'b1, 0, 0, 2);
    do_op(0, 2'b11, 4, 0, 1'b1, 6, 0, 2);
    do_op(0, 2'b10, 7, 9, 1'b1, 3, 0, 5);
    do_op(0, 2'b10, 9, 0, 1'b1, 0, 0, 5);
    do_op(0, 2'b00, 12, 1, 1'b1, 0, 1, 1);
    do_op(0, 2'b00, 4, 3, 1'b1, 7, 0, 2);
    do_op(0, 2'b01, 0, 9, 1'b1, 1, 0, 2);
    do_op(0, 2'b11, 5, 12, 1'b1, 5, 0, 2);
    do_op(1, 2'b00, 15, 15, 1'b1, 14, 0, 2);
    do_op(1, 2'b10, 15, 15, 1'b1, 1, 0, 5);
    do_op(2, 2'b10, 16, 16, 1'b1, 1, 0, 6);
    do_op(2, 2'b01, 3, 20, 1'b1, 0, 1, 1);

    // result stalls under backpressure while new requests are refused
    ordy[0] = 1'b0;
    do_op(0, 2'b00, 9, 9, 1'b1, 8, 0, 2);
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1; opv[0] = 2'b00; xv[0] = 1; yv[0] = 1;
      @(posedge clk); #1;
      check("stall_z", 0, zv[0], 8);
      check("stall_vld", 0, int'(ov[0]), 1);
      check("stall_rdy", 0, int'(rdy[0]), 0);
    end
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    check("xfer_vld", 0, int'(ov[0]), 0);
    check("xfer_rdy", 0, int'(rdy[0]), 1);
    repeat (3) @(posedge clk);
    #1 check("single_xfer", 0, int'(ov[0]), 0);

    // reset sampled in the second cycle of a MUL discards it
    iv[0] = 1'b1; opv[0] = 2'b10; xv[0] = 7; yv[0] = 9;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_vld", 0, int'(ov[0]), 0);
    check("mrst_z", 0, zv[0], 0);
    check("mrst_rdy", 0, int'(rdy[0]), 1);
    check("mrst_err", 0, int'(ev[0]), 0);
    repeat (6) @(posedge clk);
    #1 check("mrst_no_result", 0, int'(ov[0]), 0);

    fork
      sweep(0);
      sweep(1);
      sweep(2);
    join

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
